// File: rtl/holly_bus_router.sv
// rtl/holly_bus_router.sv - registered N-target SH4 data-side request router for the HOLLY map
//
// Decodes each CPU data request against per-target address windows and
// forwards it to one target over a level req/ack handshake. It returns the
// selected target's read data, and reports unmapped accesses and target
// timeouts as bus errors with a sticky first-error capture.
//
// Ports:
//   clock, reset_n         system clock (posedge), asynchronous active-low reset
//   cpu_req_*              CPU request: addr[28:0] decoded, wdata, wmask, wen, valid (held until resp)
//   cpu_resp_*             one-cycle response strobe with rdata and err qualifier
//   tgt_sel/tgt_req        one-hot target select and level request, held while waiting
//   tgt_addr/wdata/wmask/wen  latched request fields toward the targets
//   tgt_rdata/tgt_ack      per-target read data and one-cycle completion
//   err_flag/addr/is_to    sticky first-error capture, cleared by err_clr
module holly_bus_router #(
  parameter int                  N_TGT     = 4,
  parameter int                  ADDR_W    = 16,
  parameter logic [N_TGT*29-1:0] TGT_BASE  = {N_TGT{29'h0}},
  parameter logic [N_TGT*29-1:0] TGT_LIMIT = {N_TGT{29'h0}},
  parameter int                  TIMEOUT   = 255,
  parameter int                  TO_W      = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         cpu_req_addr,
  input  logic [63:0]         cpu_req_wdata,
  input  logic [7:0]          cpu_req_wmask,
  input  logic                cpu_req_wen,
  input  logic                cpu_req_valid,
  output logic [63:0]         cpu_resp_rdata,
  output logic                cpu_resp_valid,
  output logic                cpu_resp_err,
  output logic [N_TGT-1:0]    tgt_sel,
  output logic                tgt_req,
  output logic [ADDR_W-1:0]   tgt_addr,
  output logic [63:0]         tgt_wdata,
  output logic [7:0]          tgt_wmask,
  output logic                tgt_wen,
  input  logic [N_TGT*64-1:0] tgt_rdata,
  input  logic [N_TGT-1:0]    tgt_ack,
  output logic                err_flag,
  output logic [28:0]         err_addr,
  output logic                err_is_to,
  input  logic                err_clr
);

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [63:0]     ERR_DATA = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [TO_W-1:0]     r_cnt;
  logic [28:0]         r_addr;
  logic                r_is_to;
  logic [N_TGT-1:0]    r_sel;
  logic                r_req;
  logic [ADDR_W-1:0]   r_tgt_addr;
  logic [63:0]         r_wdata;
  logic [7:0]          r_wmask;
  logic                r_wen;
  logic [63:0]         r_rdata;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic                r_err_flag;
  logic [28:0]         r_err_addr;
  logic                r_err_is_to;

  logic [N_TGT-1:0]    w_hit_sel;
  logic [63:0]         w_ack_rdata;
  logic                w_ack;
  logic                w_timeout;
  logic                w_unused;

  // The CPU's top three address bits are region/cache attributes, not decoded.
  assign w_unused = ^cpu_req_addr[31:29];

  // Scan from the highest index down so the lowest matching window wins.
  always_comb begin
    w_hit_sel = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if ((cpu_req_addr[28:0] >= TGT_BASE[29*i +: 29]) &&
          (cpu_req_addr[28:0] <= TGT_LIMIT[29*i +: 29])) begin
        w_hit_sel    = '0;
        w_hit_sel[i] = 1'b1;
      end
    end
  end

  // r_sel is one-hot while waiting and zero otherwise, so masking the acks
  // and data with it ignores every non-selected or out-of-phase ack.
  always_comb begin
    w_ack_rdata = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (r_sel[i]) begin
        w_ack_rdata = w_ack_rdata | tgt_rdata[64*i +: 64];
      end
    end
  end

  assign w_ack     = |(tgt_ack & r_sel);
  assign w_timeout = (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req_valid) w_state_nxt = (|w_hit_sel) ? S_WAIT : S_RESP;
      S_WAIT:  if (w_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_is_to      <= 1'b0;
      r_sel        <= '0;
      r_req        <= 1'b0;
      r_tgt_addr   <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_wen        <= 1'b0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (cpu_req_valid) begin
            r_addr     <= cpu_req_addr[28:0];
            r_tgt_addr <= cpu_req_addr[ADDR_W-1:0];
            r_wdata    <= cpu_req_wdata;
            r_wmask    <= cpu_req_wmask;
            r_wen      <= cpu_req_wen;
            if (|w_hit_sel) begin
              r_sel <= w_hit_sel;
              r_req <= 1'b1;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_rdata      <= ERR_DATA;
              r_is_to      <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // Ack is tested first so an ack on the last allowed cycle still completes.
          if (w_ack) begin
            r_sel        <= '0;
            r_req        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_rdata      <= r_wen ? 64'h0 : w_ack_rdata;
          end else if (w_timeout) begin
            r_sel        <= '0;
            r_req        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_rdata      <= ERR_DATA;
            r_is_to      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_cnt      <= '0;
          r_resp_err <= 1'b0;
          r_rdata    <= '0;
        end
        default: begin
          r_cnt <= '0;
          r_sel <= '0;
          r_req <= 1'b0;
        end
      endcase
    end
  end

  // First-error capture; a new error beats a coincident clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_flag  <= 1'b0;
      r_err_addr  <= '0;
      r_err_is_to <= 1'b0;
    end else if (r_resp_valid && r_resp_err && (!r_err_flag || err_clr)) begin
      r_err_flag  <= 1'b1;
      r_err_addr  <= r_addr;
      r_err_is_to <= r_is_to;
    end else if (err_clr) begin
      r_err_flag  <= 1'b0;
      r_err_addr  <= '0;
      r_err_is_to <= 1'b0;
    end
  end

  assign cpu_resp_rdata = r_rdata;
  assign cpu_resp_valid = r_resp_valid;
  assign cpu_resp_err   = r_resp_err;
  assign tgt_sel        = r_sel;
  assign tgt_req        = r_req;
  assign tgt_addr       = r_tgt_addr;
  assign tgt_wdata      = r_wdata;
  assign tgt_wmask      = r_wmask;
  assign tgt_wen        = r_wen;
  assign err_flag       = r_err_flag;
  assign err_addr       = r_err_addr;
  assign err_is_to      = r_err_is_to;

endmodule

// File: tb/tb_holly_bus_router.sv
// tb/tb_holly_bus_router.sv - randomized self-checking bench for holly_bus_router
module tb_holly_bus_router;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [31:0]   cpu_req_addr;
  logic [63:0]   cpu_req_wdata;
  logic [7:0]    cpu_req_wmask;
  logic          cpu_req_wen;
  logic          cpu_req_valid;
  logic [63:0]   cpu_resp_rdata;
  logic          cpu_resp_valid;
  logic          cpu_resp_err;
  logic [N-1:0]  tgt_sel;
  logic          tgt_req;
  logic [15:0]   tgt_addr;
  logic [63:0]   tgt_wdata;
  logic [7:0]    tgt_wmask;
  logic          tgt_wen;
  logic [N*64-1:0] tgt_rdata;
  logic [N-1:0]  tgt_ack;
  logic          err_flag;
  logic [28:0]   err_addr;
  logic          err_is_to;
  logic          err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [28:0] base_a [N] = '{29'h005F7C00, 29'h04000000, 29'h0C000000, 29'h00000000};
  logic [28:0] lim_a  [N] = '{29'h005F7CFF, 29'h047FFFFF, 29'h0CFFFFFF, 29'h0FFFFFFF};

  logic        m_flag;
  logic [28:0] m_addr;
  logic        m_to;

  always #5 clock = ~clock;

  holly_bus_router #(
    .N_TGT    (N),
    .ADDR_W   (16),
    .TGT_BASE ({29'h00000000, 29'h0C000000, 29'h04000000, 29'h005F7C00}),
    .TGT_LIMIT({29'h0FFFFFFF, 29'h0CFFFFFF, 29'h047FFFFF, 29'h005F7CFF}),
    .TIMEOUT  (TO),
    .TO_W     (5)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wmask (cpu_req_wmask),
    .cpu_req_wen   (cpu_req_wen),
    .cpu_req_valid (cpu_req_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_err  (cpu_resp_err),
    .tgt_sel       (tgt_sel),
    .tgt_req       (tgt_req),
    .tgt_addr      (tgt_addr),
    .tgt_wdata     (tgt_wdata),
    .tgt_wmask     (tgt_wmask),
    .tgt_wen       (tgt_wen),
    .tgt_rdata     (tgt_rdata),
    .tgt_ack       (tgt_ack),
    .err_flag      (err_flag),
    .err_addr      (err_addr),
    .err_is_to     (err_is_to),
    .err_clr       (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [28:0] a);
    for (int i = 0; i < N; i++) begin
      if (a >= base_a[i] && a <= lim_a[i]) return i;
    end
    return -1;
  endfunction

  // One CPU transaction. Cycle 0 is the cycle whose closing edge samples
  // the request; ack_k is the cycle the selected target acks (outside
  // 1..TO means it never acks in time); stray_t/stray_c pulse another ack.
  task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int ack_k, input int stray_t,
                         input int stray_c, input logic clr, input logic set_rd,
                         input logic [63:0] sel_rd);
    int              idx;
    int              exp_cyc;
    logic            exp_err;
    logic            exp_to;
    logic [63:0]     exp_rd;
    logic [N-1:0]    exp_sel;
    logic [N*64-1:0] rd;
    rd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    idx = decode(addr[28:0]);
    if (idx >= 0 && set_rd) rd[64*idx +: 64] = sel_rd;
    exp_sel = '0;
    if (idx < 0) begin
      exp_cyc = 1; exp_err = 1'b1; exp_to = 1'b0; exp_rd = '1;
    end else begin
      exp_sel[idx] = 1'b1;
      if (ack_k >= 1 && ack_k <= TO) begin
        exp_cyc = ack_k + 1; exp_err = 1'b0; exp_to = 1'b0;
        exp_rd  = wen ? 64'h0 : rd[64*idx +: 64];
      end else begin
        exp_cyc = TO + 1; exp_err = 1'b1; exp_to = 1'b1; exp_rd = '1;
      end
    end
    tgt_rdata = rd;
    for (int c = 0; c <= exp_cyc; c++) begin
      @(negedge clock);
      if (c > 0 && c < exp_cyc) begin
        check("tgt_req", 64'(tgt_req), 64'd1);
        check("tgt_sel", 64'(tgt_sel), 64'(exp_sel));
        check("resp_early", 64'(cpu_resp_valid), 64'd0);
        if (c == 1) begin
          check("tgt_addr", 64'(tgt_addr), 64'(addr[15:0]));
          check("tgt_wdata", tgt_wdata, wdata);
          check("tgt_wmask", 64'(tgt_wmask), 64'(wmask));
          check("tgt_wen", 64'(tgt_wen), 64'(wen));
        end
      end else if (c == exp_cyc) begin
        check("resp_valid", 64'(cpu_resp_valid), 64'd1);
        check("resp_err", 64'(cpu_resp_err), 64'(exp_err));
        check("resp_rdata", cpu_resp_rdata, exp_rd);
        check("req_drop", 64'(tgt_req), 64'd0);
        check("sel_drop", 64'(tgt_sel), 64'd0);
      end
      if (c == 0) begin
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        cpu_req_wmask = wmask;
        cpu_req_wen   = wen;
      end
      cpu_req_valid = (c < exp_cyc);
      tgt_ack = '0;
      if (idx >= 0 && c == ack_k) tgt_ack[idx] = 1'b1;
      if (stray_t >= 0 && stray_t != idx && c == stray_c) tgt_ack[stray_t] = 1'b1;
      err_clr = (c == exp_cyc) ? clr : 1'b0;
    end
    if (exp_err && (!m_flag || clr)) begin
      m_flag = 1'b1; m_addr = addr[28:0]; m_to = exp_to;
    end else if (clr) begin
      m_flag = 1'b0; m_addr = '0; m_to = 1'b0;
    end
    @(negedge clock);
    tgt_ack = '0;
    err_clr = 1'b0;
    check("resp_once", 64'(cpu_resp_valid), 64'd0);
    check("err_flag", 64'(err_flag), 64'(m_flag));
    check("err_addr", 64'(err_addr), 64'(m_addr));
    check("err_is_to", 64'(err_is_to), 64'(m_to));
  endtask

  task automatic idle_clear();
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    m_flag = 1'b0; m_addr = '0; m_to = 1'b0;
    check("clr_flag", 64'(err_flag), 64'd0);
    check("clr_addr", 64'(err_addr), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] a29;
    logic [2:0]  hi;
    int          mode;
    int          st;
    reset_n = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_wmask = '0; cpu_req_wen = 1'b0;
    cpu_req_valid = 1'b0; tgt_rdata = '0; tgt_ack = '0; err_clr = 1'b0;
    m_flag = 1'b0; m_addr = '0; m_to = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req", 64'(tgt_req), 64'd0);
    check("rst_sel", 64'(tgt_sel), 64'd0);
    check("rst_resp", 64'(cpu_resp_valid), 64'd0);
    check("rst_err", 64'(cpu_resp_err), 64'd0);
    check("rst_rdata", cpu_resp_rdata, 64'd0);
    check("rst_eflag", 64'(err_flag), 64'd0);
    check("rst_eaddr", 64'(err_addr), 64'd0);
    reset_n = 1'b1;

    // Directed cases from the plan.
    run_txn(32'h005F7C10, 1'b0, 64'h1, 8'hFF, 3, -1, 0, 1'b0, 1'b1, 64'h0000000012345678);
    run_txn(32'hA5000000, 1'b0, 64'h2, 8'h0F, 5, 2, 2, 1'b0, 1'b0, 64'h0);
    run_txn(32'h10000000, 1'b1, 64'hDEAD_BEEF_0000_1111, 8'hF0, 0, -1, 0, 1'b0, 1'b0, 64'h0);
    idle_clear();
    run_txn(32'h0C000100, 1'b0, 64'h3, 8'h01, 0, -1, 0, 1'b0, 1'b0, 64'h0);
    run_txn(32'h12345678, 1'b0, 64'h4, 8'h01, 0, -1, 0, 1'b0, 1'b0, 64'h0);
    idle_clear();
    run_txn(32'h04000040, 1'b0, 64'h5, 8'h3C, TO, 0, 7, 1'b0, 1'b1, 64'hCAFE_F00D_1234_5678);
    run_txn(32'h10000000, 1'b0, 64'h6, 8'h01, 0, -1, 0, 1'b0, 1'b0, 64'h0);
    run_txn(32'h1F000020, 1'b1, 64'h7, 8'h80, 0, -1, 0, 1'b1, 1'b0, 64'h0);
    idle_clear();

    // Reset while waiting on a target.
    @(negedge clock);
    cpu_req_addr = 32'h005F7C10; cpu_req_wen = 1'b0; cpu_req_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("pre_rst_req", 64'(tgt_req), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_req", 64'(tgt_req), 64'd0);
    check("async_resp", 64'(cpu_resp_valid), 64'd0);
    cpu_req_valid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("rst_no_resp", 64'(cpu_resp_valid), 64'd0);
    end
    reset_n = 1'b1;
    m_flag = 1'b0; m_addr = '0; m_to = 1'b0;
    run_txn(32'h005F7C00, 1'b0, 64'h8, 8'hFF, 2, -1, 0, 1'b0, 1'b0, 64'h0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0:       a29 = 29'h005F7C00 + 29'($urandom_range(0, 255));
        1:       a29 = 29'h04000000 + 29'($urandom_range(0, 32'h7FFFFF));
        2:       a29 = 29'h0C000000 + 29'($urandom_range(0, 32'hFFFFFF));
        3:       a29 = 29'($urandom) & 29'h0FFFFFFF;
        default: a29 = 29'h10000000 | (29'($urandom) & 29'h0FFFFFFF);
      endcase
      hi = 3'($urandom);
      st = $urandom_range(0, 4);
      run_txn({hi, a29}, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, TO + 2), (st == 4) ? -1 : st, $urandom_range(0, TO + 1),
              ($urandom_range(0, 7) == 0), 1'b0, 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/holly_bus_router.md
Name: holly_bus_router

Overview:
Parametrised SH4 data-side request router for the HOLLY address map. It replaces the flat combinational chip-select and read-mux logic with a registered, N-target router. The router decodes each CPU data request against per-target address windows and forwards it to exactly one target with a level request/ack handshake. It returns muxed read data, and reports unmapped accesses and target timeouts as bus errors with a sticky error capture.

Parameters:
N_TGT, 4, number of target channels (1..16)
ADDR_W, 16, width of tgt_addr (low bits of CPU address forwarded to target)
TGT_BASE, {N_TGT{29'h0}}, flat N_TGT*29-bit vector; window base for target i at bits [29*i+28:29*i]
TGT_LIMIT, {N_TGT{29'h0}}, flat N_TGT*29-bit vector; inclusive window limit for target i
TIMEOUT, 255, WAIT cycles without ack before a timeout error (>=1)
TO_W, 8, timeout counter width (2^TO_W > TIMEOUT)

Ports:
clock  in  1  system clock, all logic posedge
reset_n  in  1  asynchronous, active-low reset
cpu_req_addr  in  32  CPU request address; only bits [28:0] are decoded
cpu_req_wdata  in  64  write data
cpu_req_wmask  in  8  byte write mask
cpu_req_wen  in  1  1=write, 0=read
cpu_req_valid  in  1  request valid; CPU holds it until cpu_resp_valid
cpu_resp_rdata  out  64  read data / error pattern
cpu_resp_valid  out  1  one-cycle response strobe
cpu_resp_err  out  1  qualifies cpu_resp_valid: unmapped or timeout
tgt_sel  out  N_TGT  one-hot selected target, held during WAIT
tgt_req  out  1  request to selected target, level, held until ack/timeout
tgt_addr  out  ADDR_W  cpu_req_addr[ADDR_W-1:0] latched
tgt_wdata  out  64  latched write data
tgt_wmask  out  8  latched mask
tgt_wen  out  1  latched write enable
tgt_rdata  in  N_TGT*64  per-target read data, target i at [64*i+63:64*i]
tgt_ack  in  N_TGT  per-target completion, one cycle
err_flag  out  1  sticky: any error since last clear
err_addr  out  29  address of first error since last clear
err_is_to  out  1  1=first error was timeout, 0=unmapped
err_clr  in  1  clears err_flag/err_addr/err_is_to

Behaviour:
- Reset: state IDLE. All outputs are 0, including tgt_sel, tgt_req, cpu_resp_*, err_*. The timeout counter is 0.
- Decode: hit[i] = (addr[28:0] >= BASE_i) && (addr[28:0] <= LIMIT_i). The lowest index wins on overlap. No hit means unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Samples cpu_req_valid. If set, the address, wdata, wmask and wen are latched.
  - Mapped: go to WAIT; tgt_sel is one-hot and tgt_req=1 from the next cycle.
  - Unmapped: go to RESP with err.
- WAIT:
  - Each cycle without tgt_ack[sel], the counter increments.
  - tgt_ack[sel]=1: capture tgt_rdata[sel] (0 for writes), drop tgt_req/tgt_sel next cycle, go to RESP ok.
  - Counter reaches TIMEOUT without ack: drop tgt_req, go to RESP with err and timeout.
  - Ack and timeout in the same cycle: ack wins.
  - Acks on non-selected targets are ignored in all states.
  - Any ack in IDLE/RESP is ignored.
- RESP:
  - cpu_resp_valid=1 for exactly one cycle, then IDLE. The counter is cleared.
  - cpu_resp_err=1 on error, and cpu_resp_rdata=64'hFFFF_FFFF_FFFF_FFFF (reads and writes alike).
  - Ok write: cpu_resp_rdata=0.
- Latency, with request accepted at cycle 0:
  - Unmapped: resp at cycle 1.
  - Ack at cycle k>=1: resp at cycle k+1, so minimum 2.
  - Timeout: tgt_req is high for cycles 1..TIMEOUT; resp at TIMEOUT+1.
- cpu_req_valid outside IDLE is ignored. In the cycle after RESP (IDLE), a still-high valid is treated as a new request. The CPU must drop valid on cpu_resp_valid.
- Error capture: on an error in RESP, if err_flag=0, set err_flag and load err_addr/err_is_to. Later errors do not overwrite. err_clr coincident with a new error: set wins, loading the new error.
- Reset mid-operation: tgt_req and cpu_resp_valid drop asynchronously; the pending request produces no response.
- Outputs are registered; there is no combinational path from cpu_req_* to tgt_*.

Test Plan:
Setup for all scenarios: N_TGT=4, T0=005F7C00..005F7CFF, T1=04000000..047FFFFF, T2=0C000000..0CFFFFFF, T3=00000000..0FFFFFFF (overlaps all), TIMEOUT=16.
1. Read 0x005F7C10, T0 acks at cycle 3 with rdata 0x12345678 -> tgt_sel=0001 and tgt_addr=0x7C10 on cycles 1-3; resp at cycle 4 with rdata 0x0000000012345678, err=0.
2. Read 0xA5000000 (maps to 0x05000000, only T3) -> tgt_sel=1000; T2 pulses ack at cycle 2 and is ignored; T3 acks at cycle 5 -> resp at cycle 6.
3. Write 0x10000000 (unmapped) -> resp at cycle 1 with err=1 and rdata all-ones; err_flag=1, err_addr=0x10000000, err_is_to=0.
4. Read 0x0C000100, no ack -> tgt_req high for cycles 1-16, resp err at cycle 17; err_is_to=1. A second error afterwards leaves err_addr unchanged; err_clr clears it.
5. Ack at the 16th WAIT cycle -> ok response with ack data, no error. In a separate case, err_clr in the same cycle as a new error -> err_flag stays 1 with the new address.
6. Assert reset_n=0 during WAIT -> tgt_req=0 immediately and no cpu_resp_valid. After release, a read of 0x005F7C00 completes normally.
